// File: rtl/t01_ai_move_planner_if.sv
// Handshake bundle between the AI move planner, the game FSM/engine and the placement evaluator.
interface t01_ai_move_planner_if #(
   parameter int SCORE_W = 12
);
   logic               plan_start;
   logic               abort;
   logic [4:0]         block_type;
   logic [3:0]         falling_blockX;
   logic               eval_req;
   logic [1:0]         eval_rot;
   logic [3:0]         eval_col;
   logic               eval_valid;
   logic               eval_legal;
   logic [SCORE_W-1:0] eval_score;
   logic               cmd_rotate;
   logic               cmd_left;
   logic               cmd_right;
   logic               cmd_drop;
   logic               move_ack;
   logic               busy;
   logic               plan_done;
   logic               plan_err;

   modport master (
      output plan_start, abort, block_type, falling_blockX,
      output eval_valid, eval_legal, eval_score, move_ack,
      input  eval_req, eval_rot, eval_col,
      input  cmd_rotate, cmd_left, cmd_right, cmd_drop,
      input  busy, plan_done, plan_err
   );

   modport slave (
      input  plan_start, abort, block_type, falling_blockX,
      input  eval_valid, eval_legal, eval_score, move_ack,
      output eval_req, eval_rot, eval_col,
      output cmd_rotate, cmd_left, cmd_right, cmd_drop,
      output busy, plan_done, plan_err
   );
endinterface

// File: rtl/t01_ai_move_planner.sv
// AI move planner: sweeps every (rotation, column) candidate through the evaluator, keeps the best,
// then steers the falling block there with one-cycle rotate/shift/drop commands.
module t01_ai_move_planner #(
   parameter int NUM_COLS = 10,
   parameter int SCORE_W  = 12,
   parameter int TIMEOUT  = 255
) (
   input logic                  clk,
   input logic                  rst,
   t01_ai_move_planner_if.slave bus
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SWEEP = 3'd1;
   localparam logic [2:0] S_NEXT  = 3'd2;
   localparam logic [2:0] S_ROT   = 3'd3;
   localparam logic [2:0] S_SHIFT = 3'd4;
   localparam logic [2:0] S_DROP  = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   localparam logic [3:0] LAST_COL = 4'(NUM_COLS - 1);
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   logic [2:0]         state;
   logic [1:0]         rot_cnt;
   logic [3:0]         col_cnt;
   logic [1:0]         nr_last;
   logic [1:0]         nr_last_d;
   logic [SCORE_W-1:0] best_score;
   logic               best_valid;
   logic [1:0]         best_rot;
   logic [3:0]         best_col;
   logic               wait_ack;
   logic [7:0]         tmo_cnt;
   logic               plan_err_q;
   logic               do_rot, do_left, do_right, do_drop, cmd_any;

   // Highest rotation index worth sweeping for each piece type.
   always_comb begin
      nr_last_d = 2'd0;
      case (bus.block_type)
         5'd0, 5'd2, 5'd3: nr_last_d = 2'd1;
         5'd4, 5'd5, 5'd6: nr_last_d = 2'd3;
         default:          nr_last_d = 2'd0;
      endcase
   end

   // A command is only raised when no earlier command is still awaiting its ack.
   assign do_rot   = (state == S_ROT)   && !wait_ack && (rot_cnt != best_rot);
   assign do_left  = (state == S_SHIFT) && !wait_ack && (bus.falling_blockX > best_col);
   assign do_right = (state == S_SHIFT) && !wait_ack && (bus.falling_blockX < best_col);
   assign do_drop  = (state == S_DROP)  && !wait_ack;
   assign cmd_any  = do_rot || do_left || do_right || do_drop;

   // NOTE: outputs decode straight from registered state, so abort can mask the pulses in the same cycle.
   assign bus.cmd_rotate = do_rot   && !bus.abort;
   assign bus.cmd_left   = do_left  && !bus.abort;
   assign bus.cmd_right  = do_right && !bus.abort;
   assign bus.cmd_drop   = do_drop  && !bus.abort;
   assign bus.plan_done  = (state == S_DONE) && !bus.abort;
   assign bus.busy       = (state != S_IDLE) && (state != S_DONE);
   assign bus.eval_req   = (state == S_SWEEP);
   assign bus.eval_rot   = rot_cnt;
   assign bus.eval_col   = col_cnt;
   assign bus.plan_err   = plan_err_q;

   // NOTE: every flop here is control state, so all of it is cleared by the asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         rot_cnt    <= '0;
         col_cnt    <= '0;
         nr_last    <= '0;
         best_score <= '0;
         best_valid <= 1'b0;
         best_rot   <= '0;
         best_col   <= '0;
         wait_ack   <= 1'b0;
         tmo_cnt    <= '0;
         plan_err_q <= 1'b0;
      end else if (bus.abort) begin
         state    <= S_IDLE;
         wait_ack <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (bus.plan_start) begin
               state      <= S_SWEEP;
               nr_last    <= nr_last_d;
               best_score <= '0;
               best_valid <= 1'b0;
               best_rot   <= '0;
               best_col   <= '0;
               rot_cnt    <= '0;
               col_cnt    <= '0;
               tmo_cnt    <= '0;
               wait_ack   <= 1'b0;
               plan_err_q <= 1'b0;
            end
            S_SWEEP: begin
               if (bus.eval_valid) begin
                  // Strictly greater keeps the earliest candidate on ties.
                  if (bus.eval_legal && (!best_valid || bus.eval_score > best_score)) begin
                     best_valid <= 1'b1;
                     best_score <= bus.eval_score;
                     best_rot   <= rot_cnt;
                     best_col   <= col_cnt;
                  end
                  state <= S_NEXT;
               end else if (tmo_cnt == TMO_LAST) begin
                  plan_err_q <= 1'b1;
                  state      <= S_DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            S_NEXT: begin
               tmo_cnt <= '0;
               if (col_cnt == LAST_COL) begin
                  col_cnt <= '0;
                  if (rot_cnt == nr_last) begin
                     rot_cnt <= '0;
                     if (!best_valid) begin
                        plan_err_q <= 1'b1;
                        state      <= S_DROP;
                     end else if (best_rot == 2'd0) begin
                        state <= S_SHIFT;
                     end else begin
                        state <= S_ROT;
                     end
                  end else begin
                     rot_cnt <= rot_cnt + 2'd1;
                     state   <= S_SWEEP;
                  end
               end else begin
                  col_cnt <= col_cnt + 4'd1;
                  state   <= S_SWEEP;
               end
            end
            S_ROT, S_SHIFT, S_DROP: begin
               if (wait_ack) begin
                  if (bus.move_ack) begin
                     wait_ack <= 1'b0;
                     if (state == S_DROP) state <= S_DONE;
                  end else if (tmo_cnt == TMO_LAST) begin
                     plan_err_q <= 1'b1;
                     wait_ack   <= 1'b0;
                     state      <= S_DONE;
                  end else begin
                     tmo_cnt <= tmo_cnt + 8'd1;
                  end
               end else if (cmd_any) begin
                  // An ack arriving with the pulse itself completes the command immediately.
                  tmo_cnt  <= '0;
                  wait_ack <= !bus.move_ack;
                  if (do_rot) rot_cnt <= rot_cnt + 2'd1;
                  if (do_drop && bus.move_ack) state <= S_DONE;
               end else begin
                  state <= (state == S_ROT) ? S_SHIFT : S_DROP;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_t01_ai_move_planner.sv
// Directed bench for t01_ai_move_planner: table of planning runs against an evaluator/engine model,
// plus hand-written timeout, abort, reset and repeated-start sequences.
module tb_t01_ai_move_planner;
   localparam int NUM_COLS = 10;
   localparam int SCORE_W  = 12;

   typedef enum logic [1:0] {M_ONE, M_EQ, M_ILL} mode_e;

   typedef struct {
      string      name;
      logic [4:0] btype;
      int         nr;
      mode_e      mode;
      int         tr, tc, x0, ev_lat, ack_lat;
      int         exp_evals, exp_rot, exp_left, exp_right, exp_drop, exp_err, exp_x;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   t01_ai_move_planner_if #(.SCORE_W(SCORE_W)) bus ();

   t01_ai_move_planner #(.NUM_COLS(NUM_COLS), .SCORE_W(SCORE_W), .TIMEOUT(255)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Environment configuration, written only by the main sequence.
   mode_e mode = M_ONE;
   int tr = 0, tc = 0, nr_model = 1, ev_lat = 0, ack_lat = 0, x_base = 0;
   bit eval_on = 1'b1;

   // Environment totals, written only by the environment process.
   int tot_evals = 0, tot_req = 0, tot_done = 0, tot_range = 0, tot_proto = 0;
   int tot_rot = 0, tot_left = 0, tot_right = 0, tot_drop = 0;
   int acked_l = 0, acked_r = 0;
   int ev_wait = 0, ack_wait = 0, pend_dir = 0;

   task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", what, act, exp);
      end
   endtask

   function automatic logic [14:0] outs();
      return {bus.eval_req, bus.eval_rot, bus.eval_col, bus.cmd_rotate, bus.cmd_left,
              bus.cmd_right, bus.cmd_drop, bus.busy, bus.plan_done, bus.plan_err};
   endfunction

   // Game engine position: moves take effect just after the clock edge that sees their ack.
   initial forever begin
      @(posedge clk);
      #1 bus.falling_blockX = 4'(x_base + acked_r - acked_l);
   end

   // Evaluator and game-engine responders, sampled mid-cycle.
   initial begin
      bus.eval_valid = 1'b0;
      bus.eval_legal = 1'b0;
      bus.eval_score = '0;
      bus.move_ack   = 1'b0;
      forever begin
         bit            pending;
         int            dir;
         @(negedge clk);
         bus.eval_valid = 1'b0;
         bus.move_ack   = 1'b0;
         if (bus.plan_done === 1'b1) tot_done++;
         if (bus.eval_req === 1'b1) tot_req++;
         if (bus.eval_req === 1'b1 && eval_on) begin
            if (ev_wait >= ev_lat) begin
               ev_wait = 0;
               tot_evals++;
               if (int'(bus.eval_rot) >= nr_model || int'(bus.eval_col) >= NUM_COLS) tot_range++;
               bus.eval_valid = 1'b1;
               case (mode)
                  M_ONE: begin
                     bus.eval_legal = 1'b1;
                     bus.eval_score = (int'(bus.eval_rot) == tr && int'(bus.eval_col) == tc) ? 12'd40 : 12'd0;
                  end
                  M_EQ: begin
                     bus.eval_legal = 1'b1;
                     bus.eval_score = 12'd7;
                  end
                  default: begin
                     bus.eval_legal = 1'b0;
                     bus.eval_score = 12'hfff;
                  end
               endcase
            end else begin
               ev_wait++;
            end
         end else begin
            ev_wait = 0;
         end
         pending = (ack_wait > 0);
         if (pending) begin
            ack_wait--;
            if (ack_wait == 0) begin
               bus.move_ack = 1'b1;
               if (pend_dir < 0) acked_l++;
               if (pend_dir > 0) acked_r++;
            end
         end
         if ((bus.cmd_rotate | bus.cmd_left | bus.cmd_right | bus.cmd_drop) === 1'b1) begin
            if (pending || $countones({bus.cmd_rotate, bus.cmd_left, bus.cmd_right, bus.cmd_drop}) != 1)
               tot_proto++;
            if (bus.cmd_rotate) tot_rot++;
            if (bus.cmd_left)   tot_left++;
            if (bus.cmd_right)  tot_right++;
            if (bus.cmd_drop)   tot_drop++;
            dir = bus.cmd_left ? -1 : (bus.cmd_right ? 1 : 0);
            if (ack_lat == 0) begin
               bus.move_ack = 1'b1;
               if (dir < 0) acked_l++;
               if (dir > 0) acked_r++;
            end else begin
               ack_wait = ack_lat;
               pend_dir = dir;
            end
         end
      end
   end

   task automatic setup(input vec_t v);
      mode     = v.mode;
      tr       = v.tr;
      tc       = v.tc;
      nr_model = v.nr;
      ev_lat   = v.ev_lat;
      ack_lat  = v.ack_lat;
      x_base   = v.x0 - (acked_r - acked_l);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic start_plan(input logic [4:0] bt);
      bus.block_type = bt;
      bus.plan_start = 1'b1;
      @(posedge clk);
      #1 bus.plan_start = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input bit dup);
      int s_ev, s_rot, s_l, s_r, s_d, s_done, s_rng, s_pr;
      setup(v);
      s_ev = tot_evals; s_rot = tot_rot; s_l = tot_left; s_r = tot_right; s_d = tot_drop;
      s_done = tot_done; s_rng = tot_range; s_pr = tot_proto;
      start_plan(v.btype);
      for (int c = 0; c < 3000 && tot_done == s_done; c++) begin
         @(posedge clk);
         #1;
         if (dup) begin
            bus.block_type = 5'd1;
            bus.plan_start = (c == 15 || c == 60);
         end
      end
      bus.plan_start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check({v.name, " evals"},   tot_evals - s_ev, v.exp_evals);
      check({v.name, " rotates"}, tot_rot - s_rot,  v.exp_rot);
      check({v.name, " lefts"},   tot_left - s_l,   v.exp_left);
      check({v.name, " rights"},  tot_right - s_r,  v.exp_right);
      check({v.name, " drops"},   tot_drop - s_d,   v.exp_drop);
      check({v.name, " done"},    tot_done - s_done, 1);
      check({v.name, " err"},     bus.plan_err,     v.exp_err);
      check({v.name, " col"},     bus.falling_blockX, v.exp_x);
      check({v.name, " range"},   tot_range - s_rng, 0);
      check({v.name, " proto"},   tot_proto - s_pr,  0);
      check({v.name, " busy"},    bus.busy,          0);
   endtask

   vec_t vecs[8];

   initial begin
      int s_ev, s_req, s_cmd, s_done, s_r, s_d;
      vec_t tv;
      bus.plan_start = 1'b0;
      bus.abort      = 1'b0;
      bus.block_type = '0;

      //                name        bt    nr mode   tr tc x0 ev ack  evals rot  L  R  D err x
      vecs[0] = '{"T_peak",   5'd6, 4, M_ONE, 2, 5, 0, 1, 1,  40,  2,  0, 5, 1, 0, 5};
      vecs[1] = '{"O_tie",    5'd1, 1, M_EQ,  0, 0, 4, 0, 0,  10,  0,  4, 0, 1, 0, 0};
      vecs[2] = '{"Z_illegal",5'd3, 2, M_ILL, 0, 0, 3, 0, 1,  20,  0,  0, 0, 1, 1, 3};
      vecs[3] = '{"I_right",  5'd0, 2, M_ONE, 1, 8, 3, 2, 2,  20,  1,  0, 5, 1, 0, 8};
      vecs[4] = '{"type9",    5'd9, 1, M_ONE, 0, 2, 2, 1, 0,  10,  0,  0, 0, 1, 0, 2};
      vecs[5] = '{"J_rot3",   5'd5, 4, M_ONE, 3, 9, 9, 0, 0,  40,  3,  0, 0, 1, 0, 9};
      vecs[6] = '{"L_left",   5'd4, 4, M_ONE, 3, 0, 9, 1, 3,  40,  3,  9, 0, 1, 0, 0};
      vecs[7] = '{"S_peak",   5'd2, 2, M_ONE, 1, 0, 1, 0, 1,  20,  1,  1, 0, 1, 0, 0};

      #3 check("reset outputs", outs(), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("idle outputs", outs(), 0);

      foreach (vecs[i]) run_vec(vecs[i], 1'b0);

      // plan_start pulses while busy must not restart or disturb the sweep.
      tv = vecs[0];
      tv.name = "dup_start";
      run_vec(tv, 1'b1);

      // Evaluator that never answers: 255 request cycles, then error and done with no commands.
      eval_on = 1'b0;
      setup(vecs[0]);
      s_req = tot_req; s_done = tot_done;
      s_cmd = tot_rot + tot_left + tot_right + tot_drop;
      s_ev = tot_evals;
      start_plan(5'd6);
      for (int c = 0; c < 400 && tot_done == s_done; c++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      check("tmo req cycles", tot_req - s_req, 255);
      check("tmo done", tot_done - s_done, 1);
      check("tmo err", bus.plan_err, 1);
      check("tmo cmds", tot_rot + tot_left + tot_right + tot_drop - s_cmd, 0);
      check("tmo evals", tot_evals - s_ev, 0);
      eval_on = 1'b1;

      // abort mid-SHIFT: IDLE next cycle, no pulse in the abort cycle, no further commands.
      tv = vecs[0];
      tv.ack_lat = 3;
      setup(tv);
      s_r = tot_right; s_done = tot_done;
      start_plan(5'd6);
      for (int c = 0; c < 1000 && tot_right - s_r < 2; c++) @(posedge clk);
      #1 bus.abort = 1'b1;
      check("abort shift reached", tot_right - s_r, 2);
      @(negedge clk);
      check("abort masks outputs",
            {bus.cmd_rotate, bus.cmd_left, bus.cmd_right, bus.cmd_drop, bus.plan_done}, 0);
      @(posedge clk);
      #1 bus.abort = 1'b0;
      check("abort idle", {bus.busy, bus.eval_req}, 0);
      check("abort err kept 0", bus.plan_err, 0);
      repeat (10) @(posedge clk);
      #1;
      check("abort no more rights", tot_right - s_r, 2);
      check("abort no done", tot_done - s_done, 0);

      // abort while waiting on the drop ack of an all-illegal plan keeps plan_err set.
      tv = vecs[2];
      tv.ack_lat = 5;
      setup(tv);
      s_d = tot_drop; s_done = tot_done;
      start_plan(5'd3);
      for (int c = 0; c < 1000 && tot_drop == s_d; c++) @(posedge clk);
      #1 bus.abort = 1'b1;
      @(posedge clk);
      #1 bus.abort = 1'b0;
      check("abort drop idle", bus.busy, 0);
      check("abort drop err kept", bus.plan_err, 1);
      repeat (10) @(posedge clk);
      #1 check("abort drop no done", tot_done - s_done, 0);

      // Asynchronous reset in the middle of a sweep.
      setup(vecs[0]);
      start_plan(5'd6);
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("pre-rst busy", bus.busy, 1);
      #2 rst = 1'b1;
      #1 check("rst async clear", outs(), 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 check("post-rst idle", outs(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
